// File: rtl/fifo_stream_reader.sv
// Read-side drain for the synchronous FIFO: turns rd_en/dout/empty into a
// valid/ready stream, hiding the one-cycle read latency with a 2-entry buffer.
`timescale 1ns/1ps

module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 idle
);

  // Stream handshake: a word moves on every rising edge where m_valid and
  // m_ready are both high; m_valid never drops and m_data never changes
  // while the word is waiting on m_ready.

  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic                 r_head;
  logic                 r_tail;
  logic [WIDTH-1:0]     r_buf [0:1];
  logic [CNT_WIDTH-1:0] r_xfer_count;

  logic                 w_pop;
  logic [2:0]           w_credit;

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf[r_head];
  assign w_pop   = m_valid && m_ready;

  // Occupancy the buffer will hold next cycle, counting the word already in
  // flight; a new read is only allowed while this stays below two.
  assign w_credit   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en = !rst && enable && !fifo_empty && (w_credit < 3'd2);

  assign xfer_count = r_xfer_count;
  assign idle       = (r_occ == 2'd0) && !r_inflight && fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_occ      <= w_credit[1:0];
      r_inflight <= fifo_rd_en && !fifo_empty;
      if (r_inflight) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head       <= ~r_head;
        r_xfer_count <= r_xfer_count + 1'b1;
      end
    end
  end

  // Data storage carries no reset; contents are meaningless while occ is 0.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf[r_tail] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO on the read side, expected
// word queue filled at write time, and an independent output monitor.
`timescale 1ns/1ps

module tb_fifo_stream_reader;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] xfer_count;
  logic          idle;

  logic          wr_en;
  logic [W-1:0]  wr_data;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_count (xfer_count),
    .idle       (idle)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural FIFO (registered read, registered empty) ----
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          model_cnt   = 0;
  int          outstanding = 0;
  logic        prev_rst    = 1'b1;
  logic        prev_valid  = 1'b0;
  logic        prev_ready  = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    logic [W-1:0] exp_word;
    if (prev_rst) begin
      model_cnt   = 0;
      outstanding = 0;
    end
    check("xfer_count", 32'(xfer_count), model_cnt % (1 << CW));
    check("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
    check("idle", 32'(idle), 32'(outstanding == 0 && fifo_empty));
    check("buffer_overflow", 32'(outstanding > 2), 0);
    if (!prev_rst && prev_valid && !prev_ready) begin
      check("valid_held", 32'(m_valid), 1);
      check("data_held", 32'(m_data), 32'(prev_data));
    end
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        exp_word = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(exp_word));
      end
      model_cnt++;
    end
    if (!rst) begin
      if (fifo_rd_en && !fifo_empty) outstanding++;
      if (m_valid && m_ready) outstanding--;
    end
    prev_rst   = rst;
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + W'(i);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    enable  = 1'b1;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  int rd_cnt, pop_cnt, rd_idx, v_idx, v_first, v_last, v_total, n;
  logic [W-1:0] d;

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_xfer_count", 32'(xfer_count), 0);
    check("rst_idle", 32'(idle), 1);

    // single word
    tick();
    enable = 1'b1; m_ready = 1'b1;
    write_words(1, 8'hA5);
    rd_cnt = 0; rd_idx = -1; v_idx = -1; v_total = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin rd_cnt++; if (rd_idx < 0) rd_idx = i; end
      if (m_valid) begin v_total++; if (v_idx < 0) v_idx = i; end
      tick();
    end
    check("single_rd_pulses", rd_cnt, 1);
    check("single_valid_cycles", v_total, 1);
    check("single_latency", v_idx - rd_idx, 2);
    @(negedge clk);
    check("single_xfer_count", 32'(xfer_count), 1);
    check("single_idle", 32'(idle), 1);

    // streaming 16 words; 17 transfers total wraps the 4-bit counter to 1
    tick();
    enable = 1'b0;
    write_words(16, 8'h00);
    enable = 1'b1;
    v_first = -1; v_last = -1; v_total = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid) begin
        v_total++;
        if (v_first < 0) v_first = i;
        v_last = i;
      end
      tick();
    end
    check("stream_words", v_total, 16);
    check("stream_no_bubbles", v_last - v_first, 15);
    @(negedge clk);
    check("counter_wrap", 32'(xfer_count), 1);

    // back-pressure
    tick();
    enable = 1'b0; m_ready = 1'b0;
    write_words(8, 8'h00);
    enable = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (m_valid) check("bp_head", 32'(m_data), 0);
      tick();
    end
    @(negedge clk);
    check("bp_reads", rd_cnt, 2);
    check("bp_valid", 32'(m_valid), 1);
    check("bp_rd_en_low", 32'(fifo_rd_en), 0);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rd_en", 32'(fifo_rd_en), 1);
    drain(40);

    // enable gating with a read in flight
    enable = 1'b0; m_ready = 1'b1;
    write_words(6, 8'h40);
    enable = 1'b1;
    rd_cnt = 0; pop_cnt = 0; n = 0;
    while (rd_cnt < 3 && n < 20) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (m_valid && m_ready) pop_cnt++;
      tick();
      n++;
    end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (m_valid && m_ready) pop_cnt++;
      tick();
    end
    @(negedge clk);
    check("gate_reads", rd_cnt, 3);
    check("gate_delivered", pop_cnt, 3);
    check("gate_valid_low", 32'(m_valid), 0);
    check("gate_fifo_nonempty", 32'(fifo_empty), 0);
    tick();
    drain(40);

    // reset mid-stream
    enable = 1'b0; m_ready = 1'b1;
    write_words(8, 8'h80);
    enable = 1'b1;
    rd_cnt = 0; n = 0;
    while (rd_cnt < 3 && n < 20) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (rd_cnt == 3) check("pre_rst_valid", 32'(m_valid), 1);
      tick();
      n++;
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_no_read", 32'(fifo_rd_en), 0);
    tick();
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_xfer", 32'(xfer_count), 0);
    check("mid_rst_no_read", 32'(fifo_rd_en), 0);
    tick();
    rst = 1'b0;
    write_words(1, 8'h3C);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("post_rst_first", 32'(m_data), 32'h3C);
    tick();
    drain(20);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      wr_en   = ($urandom_range(0, 1) != 0);
      if (wr_en) begin
        d = W'($urandom_range(0, 255));
        wr_data = d;
        exp_q.push_back(d);
      end
      tick();
    end
    wr_en = 1'b0;
    drain(1000);
    @(negedge clk);
    check("final_idle", 32'(idle), 1);
    check("final_valid", 32'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
